// File: rtl/gray_seq_counter_if.sv
// Control and status bundle for gray_seq_counter; master drives controls, slave is the counter.
interface gray_seq_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             wrap;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up, wrap, load, load_val,
    input  gray_out, tc, wrapped
  );

  modport slave (
    input  en, up, wrap, load, load_val,
    output gray_out, tc, wrapped
  );
endinterface

// File: rtl/gray_seq_counter.sv
// Up/down Gray-code sequence counter with Gray-coded load, wrap/saturate ends,
// terminal-count and one-cycle wrap pulse. Binary state is kept alongside the Gray output.
module gray_seq_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  gray_seq_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] load_bin;
  logic             wrapped_q;
  logic             wrapped_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(bus.load_val >> i);
    end
  end

  always_comb begin
    bin_d     = bin_q;
    wrapped_d = 1'b0;
    if (bus.load) begin
      bin_d = load_bin;
    end else if (bus.en) begin
      if (bus.up) begin
        if (bin_q != MAX) begin
          bin_d = bin_q + 1'b1;
        end else if (bus.wrap) begin
          bin_d     = '0;
          wrapped_d = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          bin_d = bin_q - 1'b1;
        end else if (bus.wrap) begin
          bin_d     = MAX;
          wrapped_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      gray_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= bin_d ^ (bin_d >> 1);
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.tc       = bus.up ? (bin_q == MAX) : (bin_q == '0);

endmodule

// File: tb/tb_gray_seq_counter.sv
// Scoreboard bench for gray_seq_counter: stimulus pushes expected outputs, a negedge monitor compares.
module tb_gray_seq_counter;

  localparam int unsigned W    = 4;
  localparam int          MAXV = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] g;
    logic         w;
    logic         tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  gray_seq_counter_if #(.WIDTH(W)) bus ();

  gray_seq_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   m_val = 0;
  bit   m_wr  = 1'b0;

  function automatic int g_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Decode by search: the binary value whose Gray image matches.
  function automatic int bin_of_gray(input int g);
    for (int v = 0; v <= MAXV; v++) begin
      if (g_of(v) == g) return v;
    end
    return 0;
  endfunction

  task automatic step(input bit e, input bit u, input bit wr, input bit ld,
                      input int lv, input bit mid_rst);
    exp_t item;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.en       = e;
    bus.up       = u;
    bus.wrap     = wr;
    bus.load     = ld;
    bus.load_val = lv[W-1:0];
    if (mid_rst) begin
      #1;
      rst   = 1'b1;
      m_val = 0;
      m_wr  = 1'b0;
    end
    item.g  = g_of(m_val);
    item.w  = m_wr;
    item.tc = u ? (m_val == MAXV) : (m_val == 0);
    exp_q.push_back(item);
    if (!mid_rst) begin
      m_wr = 1'b0;
      if (ld) begin
        m_val = bin_of_gray(lv);
      end else if (e) begin
        if (u) begin
          if (m_val < MAXV) m_val = m_val + 1;
          else if (wr) begin m_val = 0; m_wr = 1'b1; end
        end else begin
          if (m_val > 0) m_val = m_val - 1;
          else if (wr) begin m_val = MAXV; m_wr = 1'b1; end
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.gray_out !== e.g) begin
          n_fail++;
          $display("FAIL gray_out: got %b expected %b at %0t", bus.gray_out, e.g, $time);
        end
        n_tests++;
        if (bus.wrapped !== e.w) begin
          n_fail++;
          $display("FAIL wrapped: got %b expected %b at %0t", bus.wrapped, e.w, $time);
        end
        n_tests++;
        if (bus.tc !== e.tc) begin
          n_fail++;
          $display("FAIL tc: got %b expected %b at %0t", bus.tc, e.tc, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.wrap     = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;
    repeat (2) @(posedge clk);

    // Reset state, then a full up-count with wrap.
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 1, 0, 0, 0);
    // Down through zero: wrap to max, then one more step.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // Load max (1000), then saturate upward for three cycles.
    step(0, 1, 0, 1, 'b1000, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
    // Load beats enable, then step up and back down.
    step(1, 1, 1, 1, 'b1101, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    // Hold at 0110, then step down.
    step(0, 1, 1, 1, 'b0110, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // Load zero and saturate downward.
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Reach 0101, reset between edges, release and count up.
    step(0, 1, 1, 1, 'b0101, 0);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), $urandom_range(1), $urandom_range(1),
           ($urandom_range(7) == 0), $urandom_range(MAXV),
           ($urandom_range(63) == 0));
    end
    step(0, 1, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected items left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_seq_counter.md
# gray_seq_counter

Synchronous Gray-code sequence generator that sits directly upstream of the `gray2bin` decoder and supplies its `gray_in` bus. It counts up or down through the reflected-binary sequence, supports a Gray-coded parallel load, and either wraps or saturates at the ends of the range. Status outputs flag the terminal count and wrap events so downstream logic can frame sequences without decoding.

## Interface
- `WIDTH`, 4: counter width in bits; range 0 to 2^WIDTH-1 in binary order; WIDTH ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; advance one step per cycle while high.
- `up`  in  1  direction; 1 = up, 0 = down.
- `wrap`  in  1  end-of-range mode; 1 = wrap around, 0 = saturate.
- `load`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  value to load, Gray-coded.
- `gray_out`  out  WIDTH  current count, Gray-coded, registered.
- `tc`  out  1  terminal count, combinational from state and `up`.
- `wrapped`  out  1  one-cycle pulse marking a wrap.

## Operation
- Internal state: binary register `bin_q` (WIDTH bits) and registered `gray_q`, with `gray_q == bin_q ^ (bin_q >> 1)` at all times; `gray_out = gray_q`.
- Reset (async, `rst`=1): `bin_q`=0, `gray_out`=0, `wrapped`=0, held while `rst` is high.
- Per rising edge, priority `load` > `en` > hold:
  - `load`=1: `bin_q` ← Gray-to-binary of `load_val` (b[MSB]=g[MSB]; b[i]=b[i+1]^g[i]). `gray_out` becomes `load_val`. `wrapped` ← 0. `en` ignored.
  - `en`=1, `up`=1: if `bin_q` < max, `bin_q`+1. At max: `wrap`=1 → 0 and `wrapped` ← 1; `wrap`=0 → hold, `wrapped` ← 0.
  - `en`=1, `up`=0: if `bin_q` > 0, `bin_q`-1. At 0: `wrap`=1 → max and `wrapped` ← 1; `wrap`=0 → hold, `wrapped` ← 0.
  - Otherwise hold state; `wrapped` ← 0.
- Every step changes exactly one bit of `gray_out`; a wrap also changes exactly one bit (MSB).
- `tc` = (`up` & `bin_q`==max) | (!`up` & `bin_q`==0). No gating by `en`.
- `up`, `wrap` may change any cycle; the value sampled at the edge governs that step.

## Timing
- Load and step latency: 1 cycle (value visible after the sampling edge).
- `wrapped` is high exactly in the cycle `gray_out` shows the post-wrap value; never two consecutive cycles unless wrapping repeatedly (WIDTH never allows it at ≥2).
- `tc` follows `up` combinationally in the same cycle.
- Reset values: `gray_out`=0, `wrapped`=0, `tc`=!`up`.
- Reset asserted mid-count clears outputs immediately, without waiting for `clk`; the first step after release is taken on the first edge with `rst` low.
- Simultaneous `load` and `en`: load wins, no step, no wrap pulse.
- Load of max or 0 followed by `en` at the end of the range follows the normal wrap/saturate rule on the next edge.

## Test plan
- Reset, then `en`=1 `up`=1 `wrap`=1 for 16 cycles -> `gray_out` 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; `tc`=1 only while at 1000; `wrapped`=1 only in the cycle at 0000.
- From 0000, `en`=1 `up`=0 `wrap`=1 -> 1000 with `wrapped`=1, then 1001 with `wrapped`=0; `tc`=1 at 0000 before the step.
- At 1000, `up`=1 `wrap`=0 `en`=1 for 3 cycles -> `gray_out` stays 1000, `wrapped`=0, `tc`=1.
- `load`=1 `load_val`=1101 with `en`=1 -> next `gray_out`=1101 (no step); then `en`=1 `up`=1 -> 1111; then `up`=0 -> 1101.
- At 0110, `en`=0 for 2 cycles -> holds 0110; then `up`=0 `en`=1 -> 0010.
- Count to 0101, assert `rst` between edges -> `gray_out`=0000 and `wrapped`=0 before the next edge; release, `en`=1 `up`=1 -> 0001 on the first edge.
